// File: rtl/regfile_pkg.sv
// Shared register-file definitions: address/data widths, register count,
// the writeback entry layout and the hard-wired zero register index.
// Latency: n/a (types and constants only). Backpressure: n/a.
package regfile_pkg;

   localparam int AW       = 5;
   localparam int DW       = 32;
   localparam int NUM_REGS = 32;
   localparam int ZERO_REG = 0;

   // One pending register-file write.
   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_match_unit.sv
// Priority search over the occupied queue slots for the youngest entry whose
// destination equals addr. Latency: combinational. Backpressure: none.
// Ports: addr in; ent_rd/ent_data storage view; head = oldest slot index,
//        occ = occupied entries; hit/data out (both 0 when addr is x0).
module wb_match_unit #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic [AW-1:0] addr,
   input  logic [AW-1:0] ent_rd   [DEPTH],
   input  logic [DW-1:0] ent_data [DEPTH],
   input  logic [PW-1:0] head,
   input  logic [CW-1:0] occ,
   output logic          hit,
   output logic [DW-1:0] data
);
   import regfile_pkg::ZERO_REG;

   logic [PW-1:0] idx;

   // Walk from oldest to youngest; a later match overrides an earlier one,
   // so the surviving value is the youngest pending write to addr.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < occ) && (ent_rd[idx] == addr) &&
             (addr != AW'(ZERO_REG))) begin
            hit  = 1'b1;
            data = ent_data[idx];
         end
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// Writeback queue between MEM/WB and the register file write port.
// Latency: 1 cycle accept->WE3 (0 with WB_BYPASS_EN defined and queue empty).
// Backpressure: ld/alu ready from occupancy only; wb_stall holds the drain.
// Ports: ld_*/alu_* request channels, wb_stall, WE3/A3/WD3 write port,
//        A1/A2 lookups with fwd*_hit/fwd*_data, count = occupied entries.
// Optional macro WB_BYPASS_EN: empty, unstalled queue drives one request
// straight to the write port in the same cycle.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = regfile_pkg::AW,
   parameter int DW    = regfile_pkg::DW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ld_valid,
   input  logic [AW-1:0]            ld_rd,
   input  logic [DW-1:0]            ld_data,
   output logic                     ld_ready,
   input  logic                     alu_valid,
   input  logic [AW-1:0]            alu_rd,
   input  logic [DW-1:0]            alu_data,
   output logic                     alu_ready,
   input  logic                     wb_stall,
   output logic                     WE3,
   output logic [AW-1:0]            A3,
   output logic [DW-1:0]            WD3,
   input  logic [AW-1:0]            A1,
   input  logic [AW-1:0]            A2,
   output logic                     fwd1_hit,
   output logic [DW-1:0]            fwd1_data,
   output logic                     fwd2_hit,
   output logic [DW-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]   count
);
   import regfile_pkg::ZERO_REG;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] rd_mem   [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr, alu_slot;
   logic [CW-1:0] occ;

   logic empty, ld_nz, alu_nz, ld_take, alu_take;
   logic byp_ld, byp_alu, ld_push, alu_push, pop;

   assign count  = occ;
   assign empty  = (occ == '0);
   assign ld_nz  = (ld_rd  != AW'(ZERO_REG));
   assign alu_nz = (alu_rd != AW'(ZERO_REG));

   // A same-cycle load that will occupy a slot reserves it ahead of the ALU.
   assign ld_ready  = (occ < CW'(DEPTH));
   assign alu_ready = (ld_valid && ld_nz) ? (occ < CW'(DEPTH - 1))
                                          : (occ < CW'(DEPTH));

   // Accepted requests that really need a register write (x0 is dropped).
   assign ld_take  = ld_valid  && ld_ready  && ld_nz;
   assign alu_take = alu_valid && alu_ready && alu_nz;

`ifdef WB_BYPASS_EN
   logic byp_ok;
   // rst gates the bypass so nothing reaches the write port during reset.
   assign byp_ok  = empty && !wb_stall && rst;
   assign byp_ld  = byp_ok && ld_take;
   assign byp_alu = byp_ok && !ld_take && alu_take;
`else
   assign byp_ld  = 1'b0;
   assign byp_alu = 1'b0;
`endif

   assign ld_push  = ld_take  && !byp_ld;
   assign alu_push = alu_take && !byp_alu;
   assign pop      = !empty && !wb_stall;

   // Load is the older instruction, so it takes the first free slot.
   assign alu_slot = wr_ptr + PW'(ld_push);

   always_comb begin
      WE3 = 1'b0;
      A3  = '0;
      WD3 = '0;
      if (!empty) begin
         WE3 = pop;
         A3  = rd_mem[rd_ptr];
         WD3 = data_mem[rd_ptr];
      end else if (byp_ld) begin
         WE3 = 1'b1;
         A3  = ld_rd;
         WD3 = ld_data;
      end else if (byp_alu) begin
         WE3 = 1'b1;
         A3  = alu_rd;
         WD3 = alu_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         wr_ptr <= wr_ptr + PW'(ld_push) + PW'(alu_push);
         occ    <= occ + CW'(ld_push) + CW'(alu_push) - CW'(pop);
      end
   end

   // Payload storage needs no reset: every read is qualified by occ.
   always_ff @(posedge clk) begin
      if (ld_push) begin
         rd_mem[wr_ptr]   <= ld_rd;
         data_mem[wr_ptr] <= ld_data;
      end
      if (alu_push) begin
         rd_mem[alu_slot]   <= alu_rd;
         data_mem[alu_slot] <= alu_data;
      end
   end

   wb_match_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match1 (
      .addr     (A1),
      .ent_rd   (rd_mem),
      .ent_data (data_mem),
      .head     (rd_ptr),
      .occ      (occ),
      .hit      (fwd1_hit),
      .data     (fwd1_data)
   );

   wb_match_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_match2 (
      .addr     (A2),
      .ent_rd   (rd_mem),
      .ent_data (data_mem),
      .head     (rd_ptr),
      .occ      (occ),
      .hit      (fwd2_hit),
      .data     (fwd2_data)
   );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios plus random traffic,
// expected register writes kept in a scoreboard queue, drained by a monitor.
// Runs in the default build (no bypass).
module tb_regfile_wb_queue;
   import regfile_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ld_valid, alu_valid, wb_stall;
   logic [4:0]  ld_rd, alu_rd, A1, A2, A3;
   logic [31:0] ld_data, alu_data, WD3, fwd1_data, fwd2_data;
   logic        ld_ready, alu_ready, WE3, fwd1_hit, fwd2_hit;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   // Pending writes in program order: front = next register-file write.
   wb_entry_t exp_q[$];

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .wb_stall(wb_stall), .WE3(WE3), .A3(A3), .WD3(WD3),
      .A1(A1), .A2(A2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .count(count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Youngest pending value for a register; x0 never hits.
   function automatic void model_lookup(input logic [4:0] a, output logic hit,
                                        output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (a != 5'd0)
         foreach (exp_q[i])
            if (exp_q[i].rd == a) begin
               hit = 1'b1;
               d   = exp_q[i].data;
            end
   endfunction

   // One clock of stimulus: drive at negedge, check combinational outputs
   // against the model, then record accepted writes at the rising edge.
   task automatic cycle(input logic lv, input logic [4:0] lr, input logic [31:0] ldv,
                        input logic av, input logic [4:0] ar, input logic [31:0] adv,
                        input logic st, input logic [4:0] a1v, input logic [4:0] a2v);
      int   n;
      logic e_ldr, e_alur, h;
      logic [31:0] d;
      @(negedge clk);
      ld_valid = lv;  ld_rd = lr;  ld_data = ldv;
      alu_valid = av; alu_rd = ar; alu_data = adv;
      wb_stall = st;  A1 = a1v;    A2 = a2v;
      #1;
      n      = exp_q.size();
      e_ldr  = (n < DEPTH);
      e_alur = (lv && lr != 5'd0) ? (n < DEPTH - 1) : (n < DEPTH);
      chk("count", 32'(count), 32'(n));
      chk("ld_ready", 32'(ld_ready), 32'(e_ldr));
      chk("alu_ready", 32'(alu_ready), 32'(e_alur));
      model_lookup(a1v, h, d);
      chk("fwd1_hit", 32'(fwd1_hit), 32'(h));
      chk("fwd1_data", fwd1_data, d);
      model_lookup(a2v, h, d);
      chk("fwd2_hit", 32'(fwd2_hit), 32'(h));
      chk("fwd2_data", fwd2_data, d);
      @(posedge clk);
      if (lv && e_ldr && lr != 5'd0) exp_q.push_back('{rd: lr, data: ldv});
      if (av && e_alur && ar != 5'd0) exp_q.push_back('{rd: ar, data: adv});
   endtask

   task automatic idle();
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_we3", 32'(WE3), 32'd0);
      chk("rst_a3", 32'(A3), 32'd0);
      chk("rst_wd3", WD3, 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
      chk("rst_fwd1_data", fwd1_data, 32'd0);
   endtask

   // Assert reset at a negedge (pending writes discarded), hold over one
   // rising edge, release at the following negedge.
   task automatic do_reset(input logic [4:0] a1v);
      @(negedge clk);
      rst = 1'b0;
      ld_valid = 1'b0; alu_valid = 1'b0; wb_stall = 1'b0;
      A1 = a1v; A2 = 5'd0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      @(negedge clk);
      #1;
      check_reset_outputs();
      rst = 1'b1;
   endtask

   // Monitor: every cycle, compare the write port against the scoreboard.
   initial begin
      wb_entry_t e;
      logic      exp_we;
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b1) begin
            exp_we = (exp_q.size() != 0) && !wb_stall;
            chk("we3", 32'(WE3), 32'(exp_we));
            if (exp_q.size() == 0) begin
               chk("a3_idle", 32'(A3), 32'd0);
               chk("wd3_idle", WD3, 32'd0);
            end else if (WE3 && exp_we) begin
               e = exp_q.pop_front();
               chk("a3", 32'(A3), 32'(e.rd));
               chk("wd3", WD3, e.data);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      wb_stall = 1'b0; A1 = '0; A2 = '0;

      do_reset(5'd5);

      // Single load through the queue.
      cycle(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
      repeat (2) idle();

      // Same-cycle load and ALU to one register: order and youngest forward.
      cycle(1'b1, 5'd6, 32'hA, 1'b1, 5'd6, 32'hB, 1'b0, 5'd6, 5'd6);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd6);
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd6, 5'd0);
      repeat (3) idle();

      // Fill under stall, then release: four back-to-back writes.
      for (int i = 1; i <= 4; i++)
         cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i), 1'b1, 5'(i), 5'd0);
      cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h55, 1'b1, 5'd2, 5'd3);
      repeat (6) idle();

      // Write to x0 is accepted and dropped.
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 5'd0);
      repeat (2) idle();

      // Three entries, both sources valid: only the load fits.
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(11 + i), 32'h200 + 32'(i), 1'b1, 5'd0, 5'd0);
      cycle(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88, 1'b1, 5'd7, 5'd8);
      repeat (6) idle();

      // Reset with writes pending; nothing stale may drain afterwards.
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(12 + i), 32'h300 + 32'(i), 1'b1, 5'd0, 5'd0);
      do_reset(5'd12);
      repeat (4) idle();

      // Random traffic over a small register range to force duplicates.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset(5'(($urandom_range(0, 7))));
         cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)));
      end
      repeat (8) idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side initiator for the 32x32 register file: buffers writeback requests from the load path and the ALU path and drains them, one per cycle, onto the register file write port (WE3/A3/WD3).
- Sits between the MEM/WB stage and the register file.
- Provides a pending-write lookup so the decode stage can forward values not yet committed on the read addresses A1/A2.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load writeback request.
- ld_rd  in  AW  load destination register.
- ld_data  in  DW  load result.
- ld_ready  out  1  load request accepted this cycle.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- wb_stall  in  1  holds drain; WE3 forced low.
- WE3  out  1  register file write enable.
- A3  out  AW  register file write address.
- WD3  out  DW  register file write data.
- A1  in  AW  read address 1 for lookup.
- A2  in  AW  read address 2 for lookup.
- fwd1_hit  out  1  pending write to A1 present.
- fwd1_data  out  DW  youngest pending data for A1.
- fwd2_hit  out  1  pending write to A2 present.
- fwd2_data  out  DW  youngest pending data for A2.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset: rst low asynchronously clears rd_ptr, wr_ptr and count. Outputs while reset is held or after release: WE3=0, A3=0, WD3=0, fwd*_hit=0, fwd*_data=0, count=0. Reset asserted mid-operation discards all pending entries; no write is issued.
- Storage: circular buffer of {rd, data} entries. Pointers wrap modulo DEPTH.
- Accept:
  - A source transfers on valid && ready at the rising edge.
  - ld_ready = (count < DEPTH).
  - alu_ready = (count < DEPTH-1) when ld_valid && ld_rd!=0; otherwise (count < DEPTH).
  - Ready depends on count only, never on the same-cycle pop.
- Ordering: when both sources transfer in one cycle, the load entry is enqueued first (older instruction), then the ALU entry.
- x0 writes: a request with rd==0 is accepted (ready per the rules above) and dropped; it is not enqueued and does not change count.
- Drain:
  - WE3 = !empty && !wb_stall, combinational.
  - A3/WD3 = head entry when !empty, else 0.
  - Head pops at the edge where WE3=1.
  - Minimum latency: accepted at edge N -> WE3=1 in cycle N..N+1 -> register file written at edge N+1.
- Count update: count_next = count + pushes - pop. Pushes and pop in the same cycle are legal at any occupancy, including full with a pop: ready is still 0 when full.
- Lookup:
  - fwdX_hit = 1 when AX!=0 and any occupied entry has rd==AX.
  - fwdX_data = data of the youngest matching entry (closest to the write pointer).
  - Same-cycle incoming requests are excluded from the lookup.
  - The head entry being written this cycle is included.
  - AX==0 -> hit=0, data=0.
- Duplicates: multiple entries for the same rd are drained in order; the last write wins in the register file.
- Full/empty: full means count==DEPTH; empty means count==0. No overflow or underflow is possible by construction; the assertion bench checks both.

Optional Feature:
- WB_BYPASS_EN.
- Defined: when the queue is empty and not stalled, a single valid request (load preferred; ALU if no load) is driven straight onto WE3/A3/WD3 in the same cycle and not enqueued. If both sources are valid, the ALU entry is enqueued. Latency becomes 0 cycles.
- Undefined: every request passes through the queue (minimum 1-cycle latency).

Decomposition:
- Shared package regfile_pkg: AW, DW, NUM_REGS=32, the wb_entry_t typedef {rd, data}, and ZERO_REG=0.
- One natural sub-module, wb_match_unit: a priority search returning the youngest entry matching one address. It is instantiated twice, for A1 and A2.

Test Plan:
1. Reset, then ld rd=5 data=32'h0000_0005 -> count=1; next cycle WE3=1, A3=5, WD3=32'h5; then count=0.
2. ld rd=6 data=32'hA and alu rd=6 data=32'hB in the same cycle -> writes to rd 6 in order A then B. While both are pending, A1=6 gives fwd1_hit=1, fwd1_data=32'hB.
3. wb_stall=1, issue 4 ALU writes (DEPTH=4) -> count=4, ld_ready=0, alu_ready=0, WE3=0. Release the stall -> 4 consecutive WE3 pulses in FIFO order.
4. alu rd=0 data=32'hDEAD -> alu_ready=1, count remains 0, WE3 never asserts, A1=0 gives fwd1_hit=0.
5. count=3 with both sources valid (nonzero rd) -> ld_ready=1, alu_ready=0; only the load is enqueued, count=4.
6. Assert rst low mid-drain with count=3 -> WE3=0 immediately, count=0. After release, no stale writes appear.
